// File: rtl/m65c02_bcd_addn_pkg.sv
// Shared constants for the M65C02 N-digit binary/decimal adder-subtractor.
package m65c02_add_pkg;

  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;
  localparam logic MODE_BIN = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [3:0] ADJ_ADD = 4'h6;
  localparam logic [3:0] ADJ_SUB = 4'hA;

endpackage

// File: rtl/m65c02_bcd_addn_digit.sv
// Per-digit raw sum and decimal generate/propagate terms for one BCD digit.
module m65c02_bcd_digit
  import m65c02_add_pkg::*;
(
  input  logic       i_op,
  input  logic [3:0] i_q,
  input  logic [3:0] i_r,
  output logic [3:0] o_t,
  output logic       o_g,
  output logic       o_p
);

  logic [3:0] w_m;
  logic [4:0] w_t;

  // Subtract complements the digit; the decimal thresholds shift from 9 to 15 accordingly.
  assign w_m = (i_op == OP_SUB) ? ~i_r : i_r;
  assign w_t = {1'b0, i_q} + {1'b0, w_m};
  assign o_t = w_t[3:0];
  assign o_g = (i_op == OP_SUB) ? (w_t > 5'd15) : (w_t > 5'd9);
  assign o_p = (i_op == OP_SUB) ? (w_t == 5'd15) : (w_t == 5'd9);

endmodule

// File: rtl/m65c02_bcd_addn.sv
// Two-stage N-digit binary/BCD adder-subtractor with valid/ready handshake.
module m65c02_bcd_addn
  import m65c02_add_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_vld,
  output logic                  o_in_rdy,
  input  logic                  i_op,
  input  logic                  i_mode,
  input  logic [4*DIGITS-1:0]   i_q,
  input  logic [4*DIGITS-1:0]   i_r,
  input  logic                  i_ci,
  output logic                  o_out_vld,
  input  logic                  i_out_rdy,
  output logic [4*DIGITS-1:0]   o_sum,
  output logic                  o_co,
  output logic                  o_ov,
  output logic                  o_z,
  output logic                  o_n
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]              w_m;
  logic [W:0]                w_bin;
  logic                      w_cmsb;
  logic [DIGITS-1:0][3:0]    w_t;
  logic [DIGITS-1:0]         w_g, w_p;
  logic                      w_acc, w_ld2;

  logic                      r_v1, r_v2;
  logic [DIGITS-1:0][3:0]    r_t;
  logic [DIGITS-1:0]         r_g, r_p;
  logic                      r_ci, r_op, r_mode, r_cmsb;
  logic [W:0]                r_bin;

  logic [DIGITS:0]           w_c;
  logic [3:0]                w_dig;
  logic [W-1:0]              w_dsum;
  logic [W-1:0]              w_sum;
  logic                      w_co, w_ov;

  logic [W-1:0]              r_sum;
  logic                      r_co, r_ov, r_z, r_n;

  assign w_m    = (i_op == OP_SUB) ? ~i_r : i_r;
  assign w_bin  = {1'b0, i_q} + {1'b0, w_m} + {{W{1'b0}}, i_ci};
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign w_cmsb = w_bin[W-1] ^ i_q[W-1] ^ w_m[W-1];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      m65c02_bcd_digit u_digit (
        .i_op (i_op),
        .i_q  (i_q[4*gi +: 4]),
        .i_r  (i_r[4*gi +: 4]),
        .o_t  (w_t[gi]),
        .o_g  (w_g[gi]),
        .o_p  (w_p[gi])
      );
    end
  endgenerate

  assign o_in_rdy = ~r_v1 | ~r_v2 | i_out_rdy;
  assign w_acc    = i_in_vld & o_in_rdy;
  assign w_ld2    = ~r_v2 | i_out_rdy;

  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      r_t    <= w_t;
      r_g    <= w_g;
      r_p    <= w_p;
      r_ci   <= i_ci;
      r_op   <= i_op;
      r_mode <= i_mode;
      r_bin  <= w_bin;
      r_cmsb <= w_cmsb;
    end
  end

  always_comb begin
    w_c    = '0;
    w_dig  = '0;
    w_dsum = '0;
    w_c[0] = r_ci;
    for (int i = 0; i < DIGITS; i++) begin
      w_c[i+1] = r_g[i] | (r_p[i] & w_c[i]);
      w_dig    = r_t[i] + {3'b000, w_c[i]};
      if (r_op == OP_SUB)
        w_dsum[4*i +: 4] = w_dig + (w_c[i+1] ? 4'h0 : ADJ_SUB);
      else
        w_dsum[4*i +: 4] = w_dig + (w_c[i+1] ? ADJ_ADD : 4'h0);
    end
  end

  always_comb begin
    w_sum = r_bin[W-1:0];
    w_co  = r_bin[W];
    w_ov  = r_cmsb ^ r_bin[W];
    if (r_mode == MODE_DEC) begin
      w_sum = w_dsum;
      w_co  = w_c[DIGITS];
      w_ov  = w_c[DIGITS] ^ r_op;
    end
  end

  // Result registers only change when a real operation moves in, so a stall or bubble holds them.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_sum <= '0;
      r_co  <= 1'b0;
      r_ov  <= 1'b0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
    end else begin
      if (w_ld2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_sum <= w_sum;
          r_co  <= w_co;
          r_ov  <= w_ov;
          r_z   <= (w_sum == '0);
          r_n   <= w_sum[W-1];
        end
      end
      if (w_acc)
        r_v1 <= 1'b1;
      else if (w_ld2)
        r_v1 <= 1'b0;
    end
  end

  assign o_out_vld = r_v2;
  assign o_sum     = r_sum;
  assign o_co      = r_co;
  assign o_ov      = r_ov;
  assign o_z       = r_z;
  assign o_n       = r_n;

endmodule

// File: tb/tb_m65c02_bcd_addn.sv
// Bench driving a 4-digit and a 2-digit adder in lockstep against a decimal/binary arithmetic model.
module tb_m65c02_bcd_addn;

  typedef struct packed {
    logic        op;
    logic        mode;
    logic [15:0] q;
    logic [15:0] r;
    logic        ci;
  } op_t;

  typedef struct packed {
    logic [15:0] sum4;
    logic        co4, ov4, z4, n4;
    logic [7:0]  sum2;
    logic        co2, ov2, z2, n2, vld2;
  } res_t;

  logic        clk = 1'b0;
  logic        rstN, inVld, op, mode, ci, outRdy;
  logic [15:0] q, r;
  logic        inRdy4, outVld4, co4, ov4, z4, n4;
  logic        inRdy2, outVld2, co2, ov2, z2, n2;
  logic [15:0] sum4;
  logic [7:0]  sum2;

  op_t  pendQ[$];
  res_t expQ[$];
  res_t gotQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   accepted = 0;

  always #5 clk = ~clk;

  m65c02_bcd_addn #(.DIGITS(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rstN), .i_in_vld(inVld), .o_in_rdy(inRdy4),
    .i_op(op), .i_mode(mode), .i_q(q), .i_r(r), .i_ci(ci),
    .o_out_vld(outVld4), .i_out_rdy(outRdy), .o_sum(sum4),
    .o_co(co4), .o_ov(ov4), .o_z(z4), .o_n(n4)
  );

  m65c02_bcd_addn #(.DIGITS(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rstN), .i_in_vld(inVld), .o_in_rdy(inRdy2),
    .i_op(op), .i_mode(mode), .i_q(q[7:0]), .i_r(r[7:0]), .i_ci(ci),
    .o_out_vld(outVld2), .i_out_rdy(outRdy), .o_sum(sum2),
    .o_co(co2), .o_ov(ov2), .o_z(z2), .o_n(n2)
  );

  // Returns {ov, co, sum}; decimal mode works on the operands' decimal values.
  function automatic logic [17:0] calc(op_t o, int digits);
    int          w;
    logic [16:0] mask;
    logic [15:0] s;
    logic        c, v;
    w    = 4 * digits;
    mask = (17'd1 << w) - 17'd1;
    s    = '0;
    if (o.mode) begin
      int a, b, p, res;
      a = 0; b = 0; p = 1;
      for (int i = digits - 1; i >= 0; i--) begin
        a = a * 10 + int'(o.q[4*i +: 4]);
        b = b * 10 + int'(o.r[4*i +: 4]);
        p = p * 10;
      end
      if (!o.op) begin
        res = a + b + int'(o.ci);
        c   = (res >= p);
        if (c) res = res - p;
      end else begin
        res = a - b - (o.ci ? 0 : 1);
        c   = (res >= 0);
        if (!c) res = res + p;
      end
      for (int i = 0; i < digits; i++) begin
        s[4*i +: 4] = 4'(res % 10);
        res = res / 10;
      end
      v = c ^ o.op;
    end else begin
      logic [16:0] qv, mv, tot;
      qv  = {1'b0, o.q} & mask;
      mv  = {1'b0, (o.op ? ~o.r : o.r)} & mask;
      tot = qv + mv + 17'(o.ci);
      s   = tot[15:0] & mask[15:0];
      c   = tot[w];
      v   = (qv[w-1] == mv[w-1]) && (tot[w-1] != qv[w-1]);
    end
    return {v, c, s};
  endfunction

  function automatic res_t model(op_t o);
    res_t        e;
    logic [17:0] a4, a2;
    a4 = calc(o, 4);
    a2 = calc(o, 2);
    e.sum4 = a4[15:0];  e.co4 = a4[16]; e.ov4 = a4[17];
    e.z4   = (a4[15:0] == 16'h0); e.n4 = a4[15];
    e.sum2 = a2[7:0];   e.co2 = a2[16]; e.ov2 = a2[17];
    e.z2   = (a2[7:0] == 8'h0);  e.n2 = a2[7];
    e.vld2 = 1'b1;
    return e;
  endfunction

  function automatic op_t randOp();
    op_t o;
    o.op   = 1'($urandom_range(0, 1));
    o.mode = 1'($urandom_range(0, 1));
    o.ci   = 1'($urandom_range(0, 1));
    if (o.mode) begin
      for (int i = 0; i < 4; i++) begin
        o.q[4*i +: 4] = 4'($urandom_range(0, 9));
        o.r[4*i +: 4] = 4'($urandom_range(0, 9));
      end
    end else begin
      o.q = 16'($urandom);
      o.r = 16'($urandom);
    end
    return o;
  endfunction

  // One clock of handshake: offers the head of pendQ, records accepts and delivered results.
  task automatic cycle(input bit vld, input bit ordy);
    res_t g;
    bit   acc, take;
    inVld  = vld && (pendQ.size() > 0);
    outRdy = ordy;
    if (pendQ.size() > 0) begin
      op = pendQ[0].op; mode = pendQ[0].mode;
      q  = pendQ[0].q;  r    = pendQ[0].r; ci = pendQ[0].ci;
    end
    #1;
    acc  = inVld && inRdy4;
    take = outVld4 && outRdy;
    if (take) begin
      g.sum4 = sum4; g.co4 = co4; g.ov4 = ov4; g.z4 = z4; g.n4 = n4;
      g.sum2 = sum2; g.co2 = co2; g.ov2 = ov2; g.z2 = z2; g.n2 = n2;
      g.vld2 = outVld2;
      gotQ.push_back(g);
    end
    if (acc) begin
      expQ.push_back(model(pendQ[0]));
      void'(pendQ.pop_front());
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runOne(input op_t o, output res_t g, output bit ok);
    pendQ.push_back(o);
    for (int i = 0; i < 20 && gotQ.size() == 0; i++) cycle(1'b1, 1'b1);
    ok = (gotQ.size() > 0);
    g  = '0;
    if (ok) g = gotQ.pop_front();
    expQ.delete();
    pendQ.delete();
  endtask

  task automatic test_reset;
    rstN = 1'b0; inVld = 1'b0; outRdy = 1'b0;
    op = 1'b0; mode = 1'b0; ci = 1'b0; q = '0; r = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({outVld4, sum4, co4, ov4, z4, n4, outVld2, sum2, co2, ov2, z2, n2} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got vld4=%b sum4=%h flags4=%b%b%b%b vld2=%b sum2=%h flags2=%b%b%b%b required all 0",
               outVld4, sum4, co4, ov4, z4, n4, outVld2, sum2, co2, ov2, z2, n2);
    end
    rstN = 1'b1;
    #1;
    vectors++;
    if ({inRdy4, inRdy2} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL reset_in_rdy got %b%b required 11", inRdy4, inRdy2);
    end
  endtask

  task automatic test_directed;
    res_t g;
    bit   ok;
    runOne('{op:1'b0, mode:1'b1, q:16'h0058, r:16'h0046, ci:1'b1}, g, ok);
    vectors++;
    if (!ok || {g.sum2, g.co2, g.ov2, g.z2, g.n2} !== {8'h05, 4'b1100}) begin
      miscompares++;
      $display("[TB] FAIL dec_adc_58_46 got sum=%h co=%b ov=%b z=%b n=%b required 05 1 1 0 0",
               g.sum2, g.co2, g.ov2, g.z2, g.n2);
    end
    runOne('{op:1'b1, mode:1'b1, q:16'h0000, r:16'h0001, ci:1'b1}, g, ok);
    vectors++;
    if (!ok || {g.sum2, g.co2, g.ov2, g.z2, g.n2} !== {8'h99, 4'b0101}) begin
      miscompares++;
      $display("[TB] FAIL dec_sbc_00_01 got sum=%h co=%b ov=%b z=%b n=%b required 99 0 1 0 1",
               g.sum2, g.co2, g.ov2, g.z2, g.n2);
    end
    runOne('{op:1'b0, mode:1'b1, q:16'h9999, r:16'h0000, ci:1'b1}, g, ok);
    vectors++;
    if (!ok || {g.sum4, g.co4, g.ov4, g.z4, g.n4, g.sum2, g.co2, g.z2} !== {16'h0000, 4'b1110, 8'h00, 2'b11}) begin
      miscompares++;
      $display("[TB] FAIL dec_ripple_9999 got sum4=%h co=%b ov=%b z=%b n=%b sum2=%h co2=%b z2=%b required 0000 1 1 1 0 00 1 1",
               g.sum4, g.co4, g.ov4, g.z4, g.n4, g.sum2, g.co2, g.z2);
    end
    runOne('{op:1'b0, mode:1'b0, q:16'h007F, r:16'h0001, ci:1'b0}, g, ok);
    vectors++;
    if (!ok || {g.sum2, g.co2, g.ov2, g.z2, g.n2} !== {8'h80, 4'b0101}) begin
      miscompares++;
      $display("[TB] FAIL bin_adc_7f_01 got sum=%h co=%b ov=%b z=%b n=%b required 80 0 1 0 1",
               g.sum2, g.co2, g.ov2, g.z2, g.n2);
    end
    runOne('{op:1'b1, mode:1'b1, q:16'h1234, r:16'h0001, ci:1'b1}, g, ok);
    vectors++;
    if (!ok || {g.sum4, g.co4, g.ov4, g.z4, g.n4} !== {16'h1233, 4'b1000}) begin
      miscompares++;
      $display("[TB] FAIL dec_sbc_1234_0001 got sum=%h co=%b ov=%b z=%b n=%b required 1233 1 0 0 0",
               g.sum4, g.co4, g.ov4, g.z4, g.n4);
    end
  endtask

  task automatic test_back_pressure;
    int   acc0;
    res_t e, g;
    logic [15:0] held;
    for (int i = 0; i < 4; i++) pendQ.push_back(randOp());
    acc0 = accepted;
    repeat (3) cycle(1'b1, 1'b0);
    vectors++;
    if ((accepted - acc0) != 2 || inRdy4 !== 1'b0 || outVld4 !== 1'b1 || gotQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_stall got accepted=%0d in_rdy=%b out_vld=%b delivered=%0d required 2 0 1 0",
               accepted - acc0, inRdy4, outVld4, gotQ.size());
    end
    held = sum4;
    cycle(1'b1, 1'b0);
    vectors++;
    if (expQ.size() == 0 || sum4 !== held || sum4 !== expQ[0].sum4 || co4 !== expQ[0].co4) begin
      miscompares++;
      $display("[TB] FAIL bp_hold got sum=%h co=%b held=%h required sum=%h co=%b",
               sum4, co4, held, (expQ.size() > 0) ? expQ[0].sum4 : 16'h0, (expQ.size() > 0) ? expQ[0].co4 : 1'b0);
    end
    for (int i = 0; i < 30 && gotQ.size() < 4; i++) cycle(1'b1, 1'b1);
    vectors++;
    if (gotQ.size() != 4 || expQ.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL bp_drain got %0d results for %0d accepted required 4", gotQ.size(), expQ.size());
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      g = gotQ.pop_front();
      e = expQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL bp_order got %h required %h", g, e);
      end
    end
    gotQ.delete(); expQ.delete(); pendQ.delete();
  endtask

  task automatic test_random;
    res_t e, g;
    int   n = 300;
    for (int i = 0; i < n; i++) pendQ.push_back(randOp());
    for (int i = 0; i < 4000 && gotQ.size() < n; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    vectors++;
    if (gotQ.size() != n) begin
      miscompares++;
      $display("[TB] FAIL random_timeout got %0d results required %0d", gotQ.size(), n);
    end
    while (gotQ.size() > 0 && expQ.size() > 0) begin
      g = gotQ.pop_front();
      e = expQ.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("[TB] FAIL random_result got %h required %h", g, e);
      end
    end
    gotQ.delete(); expQ.delete(); pendQ.delete();
  endtask

  task automatic test_reset_inflight;
    pendQ.push_back('{op:1'b0, mode:1'b0, q:16'h1111, r:16'h2222, ci:1'b0});
    pendQ.push_back('{op:1'b0, mode:1'b1, q:16'h0045, r:16'h0011, ci:1'b0});
    repeat (3) cycle(1'b1, 1'b0);
    vectors++;
    if (outVld4 !== 1'b1 || sum4 !== 16'h3333) begin
      miscompares++;
      $display("[TB] FAIL inflight_setup got vld=%b sum=%h required 1 3333", outVld4, sum4);
    end
    rstN = 1'b0; inVld = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({outVld4, sum4, co4, ov4, z4, n4, outVld2, sum2, co2, ov2, z2, n2} !== '0) begin
      miscompares++;
      $display("[TB] FAIL inflight_reset got vld4=%b sum4=%h vld2=%b sum2=%h flags=%b%b%b%b required all 0",
               outVld4, sum4, outVld2, sum2, co4, ov4, z4, n4);
    end
    rstN = 1'b1;
    pendQ.delete(); expQ.delete(); gotQ.delete();
    @(posedge clk);
    #1;
    vectors++;
    if (inRdy4 !== 1'b1 || outVld4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL inflight_release got in_rdy=%b out_vld=%b required 1 0", inRdy4, outVld4);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_random();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
